// File: rtl/arm_cond_pkg.sv
// Shared constants for the ARM condition unit: condition codes and flag bit positions.
package arm_cond_pkg;

    localparam int FLAG_W = 4;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;
    localparam logic [3:0] COND_NV = 4'b1111;

endpackage

// File: rtl/cond_eval.sv
// Combinational ARM condition evaluator: decides whether Cond holds for the given NZCV flags.
module cond_eval
    import arm_cond_pkg::*;
(
    input  logic [3:0]        Cond,
    input  logic [FLAG_W-1:0] Flags,
    output logic              CondEx
);

    logic n, z, c, v;

    assign n = Flags[FLAG_N];
    assign z = Flags[FLAG_Z];
    assign c = Flags[FLAG_C];
    assign v = Flags[FLAG_V];

    always_comb begin
        CondEx = 1'b0;
        case (Cond)
            COND_EQ: CondEx = z;
            COND_NE: CondEx = ~z;
            COND_CS: CondEx = c;
            COND_CC: CondEx = ~c;
            COND_MI: CondEx = n;
            COND_PL: CondEx = ~n;
            COND_VS: CondEx = v;
            COND_VC: CondEx = ~v;
            COND_HI: CondEx = c & ~z;
            COND_LS: CondEx = ~c | z;
            COND_GE: CondEx = ~(n ^ v);
            COND_LT: CondEx = n ^ v;
            COND_GT: CondEx = ~z & ~(n ^ v);
            COND_LE: CondEx = z | (n ^ v);
            COND_AL: CondEx = 1'b1;
            default: CondEx = 1'b0;
        endcase
    end

endmodule

// File: rtl/cond_unit_pipe.sv
// Execute-stage condition unit: owns NZCV, gates writes by condition/stall/flush,
// and registers the gated controls into the Memory stage.
module cond_unit_pipe
    import arm_cond_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [3:0]        CondE,
    input  logic [FLAG_W-1:0] ALUFlagsE,
    input  logic [1:0]        FlagWE,
    input  logic              PCSE,
    input  logic              RegWE,
    input  logic              MemWE,
    input  logic              NoWriteE,
    input  logic              ValidE,
    input  logic              StallE,
    input  logic              FlushE,
    output logic [FLAG_W-1:0] Flags,
    output logic              CondExE,
    output logic              ValidM,
    output logic              PCSrcM,
    output logic              RegWriteM,
    output logic              MemWriteM
);

    logic [FLAG_W-1:0] flags_q, flags_d;
    logic valid_m_q, valid_m_d;
    logic pcsrc_m_q, pcsrc_m_d;
    logic regw_m_q, regw_m_d;
    logic memw_m_q, memw_m_d;
    logic advance;
    logic commit;

    cond_eval u_cond_eval (
        .Cond   (CondE),
        .Flags  (flags_q),
        .CondEx (CondExE)
    );

    // A stalled or flushed instruction must leave no architectural trace.
    assign advance = ~StallE & ~FlushE;
    assign commit  = ValidE & CondExE & advance;

    always_comb begin
        flags_d = flags_q;
        if (commit && FlagWE[1]) begin
            flags_d[FLAG_N] = ALUFlagsE[FLAG_N];
            flags_d[FLAG_Z] = ALUFlagsE[FLAG_Z];
        end
        if (commit && FlagWE[0]) begin
            flags_d[FLAG_C] = ALUFlagsE[FLAG_C];
            flags_d[FLAG_V] = ALUFlagsE[FLAG_V];
        end

        valid_m_d = advance & ValidE;
        pcsrc_m_d = PCSE & commit;
        regw_m_d  = RegWE & ~NoWriteE & commit;
        memw_m_d  = MemWE & commit;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flags_q   <= '0;
            valid_m_q <= 1'b0;
            pcsrc_m_q <= 1'b0;
            regw_m_q  <= 1'b0;
            memw_m_q  <= 1'b0;
        end else begin
            flags_q   <= flags_d;
            valid_m_q <= valid_m_d;
            pcsrc_m_q <= pcsrc_m_d;
            regw_m_q  <= regw_m_d;
            memw_m_q  <= memw_m_d;
        end
    end

    assign Flags     = flags_q;
    assign ValidM    = valid_m_q;
    assign PCSrcM    = pcsrc_m_q;
    assign RegWriteM = regw_m_q;
    assign MemWriteM = memw_m_q;

endmodule

// File: tb/tb_cond_unit_pipe.sv
// Bench for cond_unit_pipe: directed literal checks plus randomized traffic against a flag-level model.
module tb_cond_unit_pipe;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] CondE = 4'd0;
    logic [3:0] ALUFlagsE = 4'd0;
    logic [1:0] FlagWE = 2'd0;
    logic       PCSE = 1'b0, RegWE = 1'b0, MemWE = 1'b0, NoWriteE = 1'b0;
    logic       ValidE = 1'b0, StallE = 1'b0, FlushE = 1'b0;
    logic [3:0] Flags;
    logic       CondExE, ValidM, PCSrcM, RegWriteM, MemWriteM;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en = 0;

    // Reference state held as individual flag bits.
    bit m_n, m_z, m_c, m_v;
    bit m_valid, m_pcs, m_regw, m_memw;

    cond_unit_pipe dut (
        .clk       (clk),
        .reset     (reset),
        .CondE     (CondE),
        .ALUFlagsE (ALUFlagsE),
        .FlagWE    (FlagWE),
        .PCSE      (PCSE),
        .RegWE     (RegWE),
        .MemWE     (MemWE),
        .NoWriteE  (NoWriteE),
        .ValidE    (ValidE),
        .StallE    (StallE),
        .FlushE    (FlushE),
        .Flags     (Flags),
        .CondExE   (CondExE),
        .ValidM    (ValidM),
        .PCSrcM    (PCSrcM),
        .RegWriteM (RegWriteM),
        .MemWriteM (MemWriteM)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit holds(input logic [3:0] cond, input bit n, input bit z, input bit c, input bit v);
        bit ge;
        ge = (n == v);
        case (cond)
            4'd0:  return z;
            4'd1:  return !z;
            4'd2:  return c;
            4'd3:  return !c;
            4'd4:  return n;
            4'd5:  return !n;
            4'd6:  return v;
            4'd7:  return !v;
            4'd8:  return c && !z;
            4'd9:  return !c || z;
            4'd10: return ge;
            4'd11: return !ge;
            4'd12: return !z && ge;
            4'd13: return z || !ge;
            4'd14: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            {m_n, m_z, m_c, m_v} = 4'b0000;
            {m_valid, m_pcs, m_regw, m_memw} = 4'b0000;
        end else begin
            bit go, com;
            go  = !StallE && !FlushE;
            com = ValidE && holds(CondE, m_n, m_z, m_c, m_v) && go;
            if (com && FlagWE[1]) begin m_n = ALUFlagsE[3]; m_z = ALUFlagsE[2]; end
            if (com && FlagWE[0]) begin m_c = ALUFlagsE[1]; m_v = ALUFlagsE[0]; end
            m_valid = go && ValidE;
            m_pcs   = com && PCSE;
            m_regw  = com && RegWE && !NoWriteE;
            m_memw  = com && MemWE;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("flags", Flags, {m_n, m_z, m_c, m_v});
            check("condex", {3'b0, CondExE}, {3'b0, holds(CondE, m_n, m_z, m_c, m_v)});
            check("m_ctrl", {ValidM, PCSrcM, RegWriteM, MemWriteM}, {m_valid, m_pcs, m_regw, m_memw});
        end
    end

    task automatic drive(input logic [3:0] cond, input logic [3:0] alu, input logic [1:0] fwe,
                         input logic pcs, input logic rwe, input logic mwe, input logic nowr,
                         input logic valid, input logic stall, input logic flush);
        @(negedge clk);
        #1;
        CondE = cond; ALUFlagsE = alu; FlagWE = fwe;
        PCSE = pcs; RegWE = rwe; MemWE = mwe; NoWriteE = nowr;
        ValidE = valid; StallE = stall; FlushE = flush;
        #1;
    endtask

    task automatic after_edge();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        #12;
        chk_en = 1;
        @(negedge clk);
        #1;
        reset = 1'b0;

        // Reset then AL
        drive(4'b1110, 4'b0000, 2'b00, 0, 1, 0, 0, 1, 0, 0);
        check("al_condex", {3'b0, CondExE}, 4'b0001);
        after_edge();
        check("al_regwrite", {3'b0, RegWriteM}, 4'b0001);
        check("al_flags", Flags, 4'b0000);

        // CMP sets Z, then EQ/NE
        drive(4'b1110, 4'b0100, 2'b11, 0, 1, 0, 1, 1, 0, 0);
        after_edge();
        check("cmp_regwrite", {3'b0, RegWriteM}, 4'b0000);
        check("cmp_flags", Flags, 4'b0100);
        drive(4'b0000, 4'b0000, 2'b00, 0, 1, 0, 0, 1, 0, 0);
        check("eq_condex", {3'b0, CondExE}, 4'b0001);
        drive(4'b0001, 4'b0000, 2'b00, 0, 1, 0, 0, 1, 0, 0);
        check("ne_condex", {3'b0, CondExE}, 4'b0000);
        after_edge();
        check("ne_m", {ValidM, PCSrcM, RegWriteM, MemWriteM}, 4'b1000);

        // Partial flag writes
        drive(4'b1110, 4'b1010, 2'b11, 0, 0, 0, 1, 1, 0, 0);
        after_edge();
        check("pw_base", Flags, 4'b1010);
        drive(4'b1110, 4'b0101, 2'b01, 0, 0, 0, 1, 1, 0, 0);
        after_edge();
        check("pw_cv", Flags, 4'b1001);
        drive(4'b1110, 4'b0101, 2'b10, 0, 0, 0, 1, 1, 0, 0);
        after_edge();
        check("pw_nz", Flags, 4'b0101);

        // Signed compares
        drive(4'b1110, 4'b1000, 2'b11, 0, 0, 0, 1, 1, 0, 0);
        drive(4'b1010, 4'b0000, 2'b00, 0, 0, 0, 0, 0, 0, 0);
        check("ge_1000", {3'b0, CondExE}, 4'b0000);
        drive(4'b1011, 4'b0000, 2'b00, 0, 0, 0, 0, 0, 0, 0);
        check("lt_1000", {3'b0, CondExE}, 4'b0001);
        drive(4'b1100, 4'b0000, 2'b00, 0, 0, 0, 0, 0, 0, 0);
        check("gt_1000", {3'b0, CondExE}, 4'b0000);
        drive(4'b1101, 4'b0000, 2'b00, 0, 0, 0, 0, 0, 0, 0);
        check("le_1000", {3'b0, CondExE}, 4'b0001);
        drive(4'b1110, 4'b1001, 2'b11, 0, 0, 0, 1, 1, 0, 0);
        drive(4'b1010, 4'b0000, 2'b00, 0, 0, 0, 0, 0, 0, 0);
        check("ge_1001", {3'b0, CondExE}, 4'b0001);
        drive(4'b1100, 4'b0000, 2'b00, 0, 0, 0, 0, 0, 0, 0);
        check("gt_1001", {3'b0, CondExE}, 4'b0001);

        // Stall, flush, release
        drive(4'b1110, 4'b0110, 2'b11, 1, 1, 1, 0, 1, 1, 0);
        after_edge();
        check("stall_flags", Flags, 4'b1001);
        check("stall_m", {ValidM, PCSrcM, RegWriteM, MemWriteM}, 4'b0000);
        drive(4'b1110, 4'b0110, 2'b11, 1, 1, 1, 0, 1, 0, 1);
        after_edge();
        check("flush_flags", Flags, 4'b1001);
        check("flush_m", {ValidM, PCSrcM, RegWriteM, MemWriteM}, 4'b0000);
        drive(4'b1110, 4'b0110, 2'b11, 1, 1, 1, 0, 1, 1, 1);
        after_edge();
        check("both_m", {ValidM, PCSrcM, RegWriteM, MemWriteM}, 4'b0000);
        drive(4'b1110, 4'b0110, 2'b11, 1, 1, 1, 0, 1, 0, 0);
        after_edge();
        check("release_flags", Flags, 4'b0110);
        check("release_m", {ValidM, PCSrcM, RegWriteM, MemWriteM}, 4'b1111);

        // Asynchronous reset between edges
        drive(4'b1110, 4'b1111, 2'b11, 0, 1, 0, 0, 1, 0, 0);
        after_edge();
        check("pre_rst_flags", Flags, 4'b1111);
        check("pre_rst_valid", {3'b0, ValidM}, 4'b0001);
        #2;
        reset = 1'b1;
        #1;
        check("async_flags", Flags, 4'b0000);
        check("async_m", {ValidM, PCSrcM, RegWriteM, MemWriteM}, 4'b0000);
        check("async_condex", {3'b0, CondExE}, 4'b0001);
        drive(4'b1110, 4'b1111, 2'b11, 1, 1, 1, 0, 1, 0, 0);
        after_edge();
        check("held_rst_flags", Flags, 4'b0000);
        @(negedge clk);
        #1;
        reset = 1'b0;

        // Randomized traffic with occasional async reset pulses
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            #1;
            CondE     = 4'($urandom_range(0, 15));
            ALUFlagsE = 4'($urandom_range(0, 15));
            FlagWE    = 2'($urandom_range(0, 3));
            PCSE      = 1'($urandom_range(0, 1));
            RegWE     = 1'($urandom_range(0, 1));
            MemWE     = 1'($urandom_range(0, 1));
            NoWriteE  = ($urandom_range(0, 3) == 0);
            ValidE    = ($urandom_range(0, 3) != 0);
            StallE    = ($urandom_range(0, 4) == 0);
            FlushE    = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 199) == 0) begin
                #2;
                reset = 1'b1;
                @(negedge clk);
                #2;
                reset = 1'b0;
            end
        end

        @(negedge clk);
        #1;
        chk_en = 0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
